// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM state encoding and adder width.
package adder_share_arbiter_pkg;

    localparam int ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester and response bus of the adder-sharing arbiter.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);

    // A transfer happens in a cycle where valid && ready are both high; operands are
    // sampled only then, and a requester may withdraw valid before it is granted.
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic [2:0]               rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_co;
    logic                     rsp_ready;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co, busy
    );

endinterface

// File: rtl/adder_share_arbiter_fulladder.sv
// The shared 8-bit adder: {co, sum} = a + b.
module fulladder
    import adder_share_arbiter_pkg::*;
(
    input  logic [ADD_WIDTH-1:0] a,
    input  logic [ADD_WIDTH-1:0] b,
    output logic                 co,
    output logic [ADD_WIDTH-1:0] sum
);

    assign {co, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one fulladder among NUM_REQ requesters,
// running one IDLE -> ADD -> RESP transaction at a time.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_share_arbiter_if.slave  bus,
    output state_t                dbg_state
);

    state_t               state;
    state_t               state_next;
    logic [2:0]           rr_ptr;
    logic [2:0]           gnt;
    logic [2:0]           grant;
    logic                 found;
    logic [NUM_REQ-1:0]   ready;
    int                   idx;
    logic [ADD_WIDTH-1:0] op_a;
    logic [ADD_WIDTH-1:0] op_b;
    logic [ADD_WIDTH-1:0] fa_sum;
    logic                 fa_co;
    logic [ADD_WIDTH-1:0] sum_q;
    logic                 co_q;

    // Search starts at rr_ptr and wraps, so the last-served requester ranks lowest.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && |(bus.req_valid & (NUM_REQ'(1) << idx))) begin
                found = 1'b1;
                grant = 3'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        ready      = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    ready      = NUM_REQ'(1) << grant;
                    state_next = ADD;
                end
            end
            ADD:     state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            sum_q  <= '0;
            co_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt  <= grant;
                        op_a <= bus.req_a[int'(grant)*WIDTH +: ADD_WIDTH];
                        op_b <= bus.req_b[int'(grant)*WIDTH +: ADD_WIDTH];
                    end
                end
                ADD: begin
                    sum_q <= fa_sum;
                    co_q  <= fa_co;
                end
                RESP: begin
                    if (bus.rsp_ready)
                        rr_ptr <= (gnt == 3'(NUM_REQ - 1)) ? 3'd0 : gnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    fulladder u_fulladder (
        .a   (op_a),
        .b   (op_b),
        .co  (fa_co),
        .sum (fa_sum)
    );

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = gnt;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_co    = co_q;
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: vector table, directed corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_adder_share_arbiter;
  import adder_share_arbiter_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(N), .WIDTH(8)) bus();

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          m_known = 0;
  bit          m_busy = 0;
  int          m_acc = 0;
  int          m_rr = 0;
  int          m_id = 0;
  logic [11:0] exp_q[$];
  int          grant_log[$];
  int          acc_log[$];
  logic [7:0]  a_arr[N];
  logic [7:0]  b_arr[N];

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       co;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // First valid requester at or after ptr, wrapping; -1 if none.
  function automatic int rr_search(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (((v >> i) & N'(1)) != '0) return i;
    end
    return -1;
  endfunction

  // ---------------- driver + per-cycle model check ----------------
  task automatic step(input logic [N-1:0] v, input logic rr, input logic rstn);
    logic [N-1:0] exp_ready;
    bit           exp_rv;
    int           g;
    int           s;
    @(negedge clk);
    rst_n         = rstn;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*8 +: 8] = a_arr[i];
      bus.req_b[i*8 +: 8] = b_arr[i];
    end
    #1;
    if (m_known) begin
      exp_rv    = m_busy && (cyc >= m_acc + 2);
      g         = m_busy ? -1 : rr_search(v, m_rr);
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      if (exp_rv && exp_q.size() > 0)
        chk("rsp_data", 32'({bus.rsp_id, bus.rsp_co, bus.rsp_sum}), 32'(exp_q[0]));
      if (rstn) begin
        if (g >= 0) begin
          s = int'(a_arr[g]) + int'(b_arr[g]);
          exp_q.push_back({3'(g), s[8], s[7:0]});
          grant_log.push_back(g);
          acc_log.push_back(cyc);
          m_busy = 1;
          m_acc  = cyc;
          m_id   = g;
        end else if (exp_rv && rr) begin
          void'(exp_q.pop_front());
          m_busy = 0;
          m_rr   = (m_id + 1) % N;
        end
      end
    end
    if (!rstn) begin
      m_known = 1;
      m_busy  = 0;
      m_rr    = 0;
      exp_q.delete();
    end
    cyc++;
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    a_arr[id] = a;
    b_arr[id] = b;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  steps;
    bit  accepted;
    bit  got;
    for (int i = 0; i < N; i++) set_ops(i, 8'd0, 8'd0);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    vecs[0] = '{0, 8'd2,   8'd3,   8'd5,   1'b0};
    vecs[1] = '{2, 8'd12,  8'd3,   8'd15,  1'b0};
    vecs[2] = '{2, 8'd0,   8'd1,   8'd1,   1'b0};
    vecs[3] = '{1, 8'd200, 8'd100, 8'd44,  1'b1};
    vecs[4] = '{3, 8'd255, 8'd1,   8'd0,   1'b1};
    vecs[5] = '{3, 8'd128, 8'd128, 8'd0,   1'b1};

    // Reset values
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b1);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    chk("rst_rsp_co", 32'(bus.rsp_co), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Vector table: single requester transactions
    for (int t = 0; t < 6; t++) begin
      set_ops(vecs[t].id, vecs[t].a, vecs[t].b);
      accepted = 0;
      for (int c = 0; c < 4 && !accepted; c++) begin
        step(N'(1) << vecs[t].id, 1'b1, 1'b1);
        if (bus.req_ready != '0) accepted = 1;
      end
      chk("vec_accept", 32'(accepted), 32'd1);
      got   = 0;
      steps = 0;
      for (int c = 0; c < 6 && !got; c++) begin
        step('0, 1'b1, 1'b1);
        steps++;
        if (bus.rsp_valid) begin
          got = 1;
          chk("vec_latency", 32'(steps), 32'd2);
          chk("vec_id", 32'(bus.rsp_id), 32'(vecs[t].id));
          chk("vec_sum", 32'(bus.rsp_sum), 32'(vecs[t].sum));
          chk("vec_co", 32'(bus.rsp_co), 32'(vecs[t].co));
        end
      end
      chk("vec_rsp_seen", 32'(got), 32'd1);
    end

    // Round-robin fairness with all requesters continuously valid
    step('0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) set_ops(i, 8'(i * 10), 8'(i));
    grant_log.delete();
    acc_log.delete();
    for (int c = 0; c < 15; c++) step('1, 1'b1, 1'b1);
    chk("rr_count", 32'(grant_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      chk("rr_order", 32'(grant_log[k]), 32'(k % N));
    for (int k = 1; k < acc_log.size(); k++)
      chk("rr_spacing", 32'(acc_log[k] - acc_log[k-1]), 32'd3);

    // Backpressure: stall 5 cycles in RESP
    step('0, 1'b1, 1'b0);
    set_ops(1, 8'd10, 8'd20);
    set_ops(3, 8'd7, 8'd9);
    step(4'b1010, 1'b1, 1'b1);
    chk("bp_grant", 32'(bus.req_ready), 32'b0010);
    step(4'b1010, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(4'b1010, 1'b0, 1'b1);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_no_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_hold", 32'({bus.rsp_id, bus.rsp_co, bus.rsp_sum}), 32'({3'd1, 1'b0, 8'd30}));
    end
    step(4'b1010, 1'b1, 1'b1);
    step(4'b1010, 1'b1, 1'b1);
    chk("bp_next_grant", 32'(bus.req_ready), 32'b1000);
    chk("bp_idle", 32'(bus.busy), 32'd0);
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);

    // Reset mid-operation: advance rr_ptr to 2, then reset while in ADD
    step(4'b0010, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    step(4'b0100, 1'b1, 1'b1);
    chk("mr_grant2", 32'(bus.req_ready), 32'b0100);
    step(4'b0100, 1'b1, 1'b0);
    step('1, 1'b1, 1'b1);
    chk("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("mr_first_grant", 32'(bus.req_ready), 32'b0001);
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    chk("mr_rsp_id", 32'(bus.rsp_id), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) set_ops(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      v = N'($urandom_range(0, (1 << N) - 1));
      step(v, ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) != 0));
    end
    for (int c = 0; c < 4; c++) step('0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
